// File: rtl/serial_add_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial addition sequencer that drives an external 1-bit full-adder cell.
// Two WIDTH-bit operands are loaded on an accepted start. One bit per clock is
// presented to the cell, LSB first. The cell's sum bit and carry-out come back
// combinationally in the same cycle. The carry is held in a register between
// bits, and the completed WIDTH-bit sum plus final carry are presented with a
// start/busy/done handshake.
//
// Parameter:
//   WIDTH     operand/sum width in bits (1..32), default 4
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request; accepted only in IDLE or DONE
//   op_a      operand A, sampled on the accepting edge
//   op_b      operand B, sampled on the accepting edge
//   cin_init  initial carry, sampled on the accepting edge
//   sub       (SERIAL_ADD_SUB_EN only) 1 = compute op_a - op_b
//   fa_a      to fulladder.a   (0 outside SHIFT)
//   fa_b      to fulladder.b   (0 outside SHIFT)
//   fa_cin    to fulladder.cin (0 outside SHIFT)
//   fa_s      from fulladder.s
//   fa_cout   from fulladder.cout
//   busy      high while shifting
//   done      one-cycle pulse when sum/cout have just been updated
//   sum       last completed sum
//   cout      last completed carry-out (no-borrow flag in subtract mode)
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub input and subtract mode.
// ---------------------------------------------------------------------------
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter must hold 0..WIDTH-1. Keep it at least one bit wide so that
  // WIDTH=1 still works.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;

  // The returning sum bit enters at the MSB, so after WIDTH shifts the
  // LSB-first bit stream ends up in its natural order.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_sum_next            = r_sum_sh >> 1;
    w_sum_next[WIDTH-1]   = fa_s;
  end

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1. cin_init is ignored in subtract mode.
  always_comb begin
    w_b_load     = sub ? ~op_b : op_b;
    w_carry_load = sub ? 1'b1  : cin_init;
  end
`else
  always_comb begin
    w_b_load     = op_b;
    w_carry_load = cin_init;
  end
`endif

  // The cell inputs are gated with busy, so the cell sees 0 outside SHIFT.
  assign fa_a   = r_busy & r_a_sh[0];
  assign fa_b   = r_busy & r_b_sh[0];
  assign fa_cin = r_busy & r_carry;

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

  // NOTE: the datapath registers are reset along with the control state.
  // An aborted operation must leave sum/cout at 0, not a stale partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= op_a;
            r_b_sh   <= w_b_load;
            r_carry  <= w_carry_load;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_state  <= S_IDLE;
          end
        end

        S_SHIFT: begin
          r_sum_sh <= w_sum_next;
          r_carry  <= fa_cout;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // The last bit edge publishes the result, including this bit.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_sum   <= w_sum_next;
            r_cout  <= fa_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_serial_add_seq
//
// Self-checking bench for serial_add_seq with a behavioural full-adder cell.
// The driver pushes the expected result and its completion cycle into a
// scoreboard when it issues an operation. A separate monitor pops the
// scoreboard and compares whenever done is presented. Per-bit cell drive,
// busy and result hold are checked by the driver while the operation shifts.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;

  localparam int WIDTH = 4;
  localparam logic [63:0] MASK = (64'd1 << WIDTH) - 64'd1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               done_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
  logic             sub;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int               checks = 0;
  int               errors = 0;
  int               cyc    = 0;
  exp_t             sb[$];
  logic [WIDTH-1:0] prev_sum  = '0;
  logic             prev_cout = 1'b0;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin_init (cin_init),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_s     (fa_s),
    .fa_cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
  );

  // Behavioural 1-bit full adder standing in for the fulladder cell.
  assign {fa_cout, fa_s} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("busy_at_done", busy, 1'b0);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].done_cyc) begin
        check("done_missing", done, 1'b1);
        e = sb.pop_front();
      end
    end
  end

  // Issue one operation at a negedge while the DUT is idle or done. Returns at
  // the negedge of the cycle in which done is expected.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s, input bit hold);
    exp_t        e;
    logic [63:0] full, beff, ceff, mi, carry_i;
`ifndef SERIAL_ADD_SUB_EN
    s = 1'b0;
`endif
    op_a = a; op_b = b; cin_init = c; sub = s; start = 1'b1;
    if (s) begin
      e.sum  = WIDTH'((64'(a) - 64'(b)) & MASK);
      e.cout = (a >= b);
      beff   = ~64'(b) & MASK;
      ceff   = 64'd1;
    end else begin
      full   = 64'(a) + 64'(b) + 64'(c);
      e.sum  = WIDTH'(full & MASK);
      e.cout = full[WIDTH];
      beff   = 64'(b);
      ceff   = 64'(c);
    end
    e.done_cyc = cyc + 1 + WIDTH;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      // Operands are scrambled during SHIFT; the DUT must ignore them.
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
      cin_init = 1'($urandom); sub = 1'($urandom);
      mi      = (64'd1 << i) - 64'd1;
      carry_i = ((64'(a) & mi) + (beff & mi) + ceff) >> i;
      check("busy", busy, 1'b1);
      check("fa_a", fa_a, a[i]);
      check("fa_b", fa_b, beff[i]);
      check("fa_cin", fa_cin, carry_i[0]);
      check("sum_hold", sum, prev_sum);
      check("cout_hold", cout, prev_cout);
      @(negedge clk);
    end
    prev_sum  = e.sum;
    prev_cout = e.cout;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fa_a"}, fa_a, 1'b0);
    check({tag, "_fa_b"}, fa_b, 1'b0);
    check({tag, "_fa_cin"}, fa_cin, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_sum"}, sum, '0);
    check({tag, "_cout"}, cout, 1'b0);
  endtask

  initial begin
    bit gap_sel;
    // Power-on reset with arbitrary inputs.
    rst_n = 1'b0; start = 1'b1; sub = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin_init = 1'b1;
    #2;
    check_all_zero("por");
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations, including the carry corner cases.
    do_op(WIDTH'(5), WIDTH'(3), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(WIDTH'(MASK), WIDTH'(1), 1'b0, 1'b0, 1'b0);
    do_op(WIDTH'(MASK), WIDTH'(MASK), 1'b1, 1'b0, 1'b0);   // start in the DONE cycle
    do_op(WIDTH'(0), WIDTH'(0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // start held high continuously: a new operation every WIDTH+1 cycles.
    for (int n = 0; n < 4; n++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
    do_op(WIDTH'(5), WIDTH'(3), 1'b1, 1'b1, 1'b0);
    do_op(WIDTH'(3), WIDTH'(5), 1'b0, 1'b1, 1'b0);
    do_op(WIDTH'(9), WIDTH'(9), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
`endif

    // Reset after two bit edges of 7+7 aborts the operation.
    op_a = WIDTH'(7); op_b = WIDTH'(7); cin_init = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("post_reset_busy", busy, 1'b0);
      check("post_reset_done", done, 1'b0);
    end
    do_op(WIDTH'(2), WIDTH'(2), 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Randomized operations with random gaps, holds and back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      gap_sel = 1'($urandom);
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (gap_sel) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial addition sequencer sitting directly upstream of the team's 1-bit `fulladder` cell.
- Loads two WIDTH-bit operands and drives the cell's a/b/cin inputs one bit per clock, LSB first.
- Captures the cell's s/cout back each cycle, holding carry in a register between bits.
- Presents the assembled WIDTH-bit sum plus final carry to downstream logic (display conversion) with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- start  in  1  request; sampled on rising clk; accepted only in IDLE or DONE.
- op_a  in  WIDTH  operand A; sampled on the accepting edge only.
- op_b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin_init  in  1  initial carry; sampled on the accepting edge only.
- fa_a  out  1  to fulladder.a.
- fa_b  out  1  to fulladder.b.
- fa_cin  out  1  to fulladder.cin.
- fa_s  in  1  from fulladder.s; combinational return within the same cycle.
- fa_cout  in  1  from fulladder.cout; combinational return within the same cycle.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  last completed sum.
- cout  out  1  last completed carry-out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Operand shift regs, sum shift reg, carry reg and bit counter all 0.
  - Outputs: fa_a=fa_b=fa_cin=0, busy=0, done=0, sum=0, cout=0.
  - Reset mid-SHIFT aborts the operation; the partial result is discarded and sum/cout read 0.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - start=1 at edge k: latch op_a, op_b and carry=cin_init; counter=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
  - Each edge:
    - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}.
    - carry <= fa_cout.
    - a_sh and b_sh shift right by one.
    - counter increments.
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th bit edge):
    - sum <= final sum_sh value, including this bit.
    - cout <= fa_cout.
    - go to DONE.
  - start is ignored throughout SHIFT.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1: accepted exactly as in IDLE and goes to SHIFT (back-to-back operations, no dead cycle beyond DONE).
  - start=0: go to IDLE.
- Latency and timing:
  - busy is high for cycles k+1..k+WIDTH.
  - done is high in cycle k+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- Result hold: sum/cout update only at completion; they hold their value through IDLE, DONE and the next SHIFT until the next completion.
- Outside SHIFT: fa_a, fa_b and fa_cin are driven 0.
- WIDTH=1: SHIFT lasts a single cycle.
- Arithmetic: {cout,sum} = op_a + op_b + cin_init, modulo 2^(WIDTH+1); no overflow flag.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on the accepting edge.
  - sub=1: B is latched as ~op_b and carry as 1, so sum = op_a - op_b mod 2^WIDTH; cin_init is ignored.
  - In subtract mode, cout = 1 means no borrow (op_a >= op_b).
  - sub=0: behaviour is identical to the base block.
- Undefined: the sub port does not exist and the block is add-only.

Test Plan:
- Reset: assert rst_n=0 mid-run with arbitrary inputs -> all outputs 0 immediately, state IDLE; after release with start=0, done/busy stay 0 for 10 cycles.
- WIDTH=4, A=5, B=3, cin=0, start pulse at edge k -> busy high in cycles k+1..k+4, done high only in cycle k+5, sum=8, cout=0; fa_a sequence 1,0,1,0 and fa_b sequence 1,1,0,0.
- Carry cases: A=F, B=1, cin=0 -> sum=0, cout=1; A=F, B=F, cin=1 -> sum=F, cout=1; A=0, B=0, cin=1 -> sum=1, cout=0.
- Handshake:
  - start held high continuously -> new operation every 5 cycles; operand changes during SHIFT have no effect.
  - start asserted in the DONE cycle -> next operation begins with no IDLE cycle.
  - sum holds the old value until the next done.
- Reset mid-operation after 2 bit edges of A=7, B=7 -> sum=0, cout=0, busy=0; a subsequent A=2, B=2 start gives sum=4 normally.
- With SERIAL_ADD_SUB_EN, sub=1:
  - A=5, B=3 -> sum=2, cout=1.
  - A=3, B=5 -> sum=E, cout=0.
  - A=9, B=9 -> sum=0, cout=1.
